shift_right_seq: RTL

- Multi-cycle right shifter for the single-cycle/pipelined MIPS datapath.
- Executes SRL/SRLV (logical, zero fill) and SRA/SRAV (arithmetic, sign fill) one bit position per clock.
- Serves as the right-direction counterpart to the combinational left-shift units.
- Sits beside the ALU: the control unit starts it, stalls on busy_o, and writes back data_o when done_o pulses.

---
 rtl/shift_right_seq.sv | 127 ++++++++++++
 1 files changed

// File: rtl/shift_right_seq.sv
// -----------------------------------------------------------------------------
// shift_right_seq
// Multi-cycle right shifter for the MIPS datapath. Performs SRL/SRLV (zero
// fill) and SRA/SRAV (sign fill), moving one bit position per clock. The
// control unit pulses start_i, stalls while busy_o is high and writes back
// data_o when done_o pulses.
//
// Ports:
//   clk_i    in   1        clock, rising edge
//   rst_i    in   1        asynchronous active-high reset
//   start_i  in   1        request, only sampled while idle
//   data_i   in   WIDTH    operand, latched on the accepting edge
//   shamt_i  in   SHAMT_W  shift amount, latched on the accepting edge
//   arith_i  in   1        1 = arithmetic (sign fill), 0 = logical
//   busy_o   out  1        high whenever an operation is in progress
//   done_o   out  1        one-cycle completion pulse
//   data_o   out  WIDTH    result register, held until the next completion
//
// SHAMT_W must satisfy 2**SHAMT_W >= WIDTH.
// -----------------------------------------------------------------------------
module shift_right_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic               arith_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   data_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic               fill_q, fill_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Working value after one more bit position; the fill bit was fixed at
    // acceptance, so a negative SRA saturates to all ones.
    logic [WIDTH-1:0]   shifted;
    assign shifted = {fill_q, work_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        data_d  = data_q;
        count_d = count_q;
        fill_d  = fill_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    work_d  = data_i;
                    count_d = shamt_i;
                    fill_d  = arith_i & data_i[WIDTH-1];
                    if (shamt_i != '0) begin
                        state_d = ST_SHIFT;
                    end else begin
                        // Zero shift: the operand is the result, publish it
                        // on the accepting edge.
                        state_d = ST_DONE;
                        data_d  = data_i;
                    end
                end
            end
            ST_SHIFT: begin
                work_d  = shifted;
                count_d = count_q - 1'b1;
                if (count_q == SHAMT_W'(1)) begin
                    // Last step: the result register is loaded with the final
                    // value on the same edge that enters DONE, so data_o
                    // never shows intermediate values.
                    state_d = ST_DONE;
                    data_d  = shifted;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered images of the next state; DONE is only ever
        // entered for a single cycle, so done_o is a one-cycle pulse.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
            fill_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            data_q  <= data_d;
            count_q <= count_d;
            fill_q  <= fill_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign data_o = data_q;

endmodule
